// File: rtl/config_pkg.sv
// config_pkg: shared constants, frame layout, FSM encoding and link timing for the config link
`timescale 1ps/1ps
package config_pkg;
  localparam int CLOCK_PERIOD_PS = 20833;
  localparam int BIT_PERIOD_NS = 400;
  localparam int C_NO_CFG_BITS = 24;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int TIMEOUT_BITS = 4;
  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = DATA_W - 1;
  localparam int ADDR_LSB = 16;
  localparam int ADDR_MSB = ADDR_LSB + ADDR_W - 1;
  // Unused upper address bits simply fall off the top of the shifter
  localparam int SR_W = ADDR_MSB + 1;
  typedef enum logic [2:0] {IDLE, SHIFT, WRITE, DONE, ERR_PULSE, WAIT_LOW} state_t;
  function automatic int to_cyc(input int bits, input int bit_ns, input int clk_ps);
    return bits * bit_ns * 1000 / clk_ps;
  endfunction
  localparam int TO_CYC = to_cyc(TIMEOUT_BITS, BIT_PERIOD_NS, CLOCK_PERIOD_PS);
  localparam int TO_W = $clog2(TO_CYC);
endpackage

// File: rtl/config_rx_if.sv
// config_rx_if: serial link inputs and register-file write port of the config receiver
`timescale 1ps/1ps
interface config_rx_if;
  import config_pkg::*;
  logic rx_dat;
  logic rx_clk;
  logic rx_oe;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic rx_end;
  logic rx_err;
  logic busy;
  modport master (output rx_dat, rx_clk, rx_oe, input wr_en, wr_addr, wr_data, rx_end, rx_err, busy);
  modport slave (input rx_dat, rx_clk, rx_oe, output wr_en, wr_addr, wr_data, rx_end, rx_err, busy);
endinterface

// File: rtl/config_rx_sync.sv
// cfg_sync: 2-flop synchroniser for link dat/clk/oe plus RX_CLK rise detect
`timescale 1ps/1ps
module cfg_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx_dat,
  input  logic i_rx_clk,
  input  logic i_rx_oe,
  output logic o_dat,
  output logic o_oe,
  output logic o_rise
);
  logic [2:0] r_s1, r_s2;
  logic r_s3;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= {i_rx_oe, i_rx_clk, i_rx_dat};
      r_s2 <= r_s1;
      r_s3 <= r_s2[1];
    end
  end
  assign o_dat = r_s2[0];
  assign o_oe = r_s2[2];
  assign o_rise = r_s2[1] & ~r_s3;
endmodule

// File: rtl/config_rx.sv
// config_rx: deserialises one config frame per OE window and writes addr/data to the register file
`timescale 1ps/1ps
module config_rx
  import config_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  config_rx_if.slave bus
);
  logic w_dat, w_oe, w_rise, w_last;
  state_t r_state;
  logic [4:0] r_bit_cnt;
  logic [SR_W-1:0] r_sr;
  logic [TO_W-1:0] r_to;
  logic [1:0] r_vld;
  logic r_bv, r_bit, r_armed, r_extra;
  logic r_wr_en, r_rx_end, r_rx_err, r_busy;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  cfg_sync u_sync (
    .i_clk(i_clock), .i_rst_n(i_reset_n),
    .i_rx_dat(bus.rx_dat), .i_rx_clk(bus.rx_clk), .i_rx_oe(bus.rx_oe),
    .o_dat(w_dat), .o_oe(w_oe), .o_rise(w_rise)
  );
  assign w_last = r_bit_cnt == 5'(C_NO_CFG_BITS - 1);
  // OE only arms the receiver once the synchronisers hold real line state, so OE high at reset release is no rise
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_bit_cnt <= '0;
      r_sr <= '0;
      r_to <= '0;
      r_vld <= '0;
      r_bv <= 1'b0;
      r_bit <= 1'b0;
      r_armed <= 1'b0;
      r_extra <= 1'b0;
      r_wr_en <= 1'b0;
      r_rx_end <= 1'b0;
      r_rx_err <= 1'b0;
      r_busy <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_bv <= w_rise & w_oe;
      r_bit <= w_dat;
      r_wr_en <= 1'b0;
      r_rx_end <= 1'b0;
      r_rx_err <= 1'b0;
      r_vld <= (r_vld == 2'd2) ? r_vld : r_vld + 2'd1;
      case (r_state)
        IDLE:
          if (r_vld == 2'd2) begin
            if (!w_oe) r_armed <= 1'b1;
            else if (r_armed) begin
              r_state <= SHIFT;
              r_busy <= 1'b1;
              r_armed <= 1'b0;
              r_bit_cnt <= '0;
              r_to <= '0;
            end
          end
        SHIFT:
          if (r_bv) begin
            r_sr <= {r_sr[SR_W-2:0], r_bit};
            r_to <= '0;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_last) r_state <= WRITE;
          end else if (!w_oe || r_to == TO_W'(TO_CYC - 1)) r_state <= ERR_PULSE;
          else r_to <= r_to + TO_W'(1);
        WRITE: begin
          r_wr_en <= 1'b1;
          r_rx_end <= 1'b1;
          r_wr_addr <= r_sr[ADDR_MSB:ADDR_LSB];
          r_wr_data <= r_sr[DATA_MSB:DATA_LSB];
          r_extra <= 1'b0;
          r_state <= DONE;
        end
        DONE:
          if (!w_oe) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
          end else if (r_bv && !r_extra) begin
            r_rx_err <= 1'b1;
            r_extra <= 1'b1;
          end
        ERR_PULSE: begin
          r_rx_err <= 1'b1;
          r_state <= w_oe ? WAIT_LOW : IDLE;
          r_busy <= w_oe;
        end
        WAIT_LOW:
          if (!w_oe) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.wr_en = r_wr_en;
  assign bus.rx_end = r_rx_end;
  assign bus.rx_err = r_rx_err;
  assign bus.busy = r_busy;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
endmodule
